id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
Parametrised instruction-decode stage with its own ID/EX pipeline register, valid/ready handshakes on both sides, pipeline flush, and load-use hazard bubble insertion. Decoding uses the team's existing controller (control-word generation) and imm_gen (immediate extraction, selector = control-word bits [18:16]) submodules. The stage sits between the IF/ID latch and EX. It replaces the purely combinational decode with a registered, stallable stage.

Parameters:
XLEN, 64, width of pc and immediate.
CTRL_W, 24, width of the control word produced by controller.
MEM_READ_BIT, 20, index in the control word that marks a load.

Ports:
clk  input  1  clock; all state updates on the rising edge
rstn  input  1  synchronous active-low reset
flush  input  1  synchronous kill of the stage contents (branch/exception redirect)
in_valid  input  1  IF/ID offers an instruction
in_ready  output  1  stage accepts the offered instruction this cycle
in_pc  input  XLEN  pc of the offered instruction
in_inst  input  32  offered instruction word
out_valid  output  1  ID/EX register holds a valid instruction
out_ready  input  1  EX consumes the register this cycle
out_pc  output  XLEN  registered pc
out_inst  output  32  registered instruction word
out_ctrl  output  CTRL_W  registered control word, zero when out_valid=0
out_imm  output  XLEN  registered sign-extended immediate
out_rd  output  5  registered inst[11:7]
out_rs1  output  5  registered inst[19:15]
out_rs2  output  5  registered inst[24:20]
stall_cnt  output  32  hazard-stall cycle count (see Optional Feature)
bubble_cnt  output  32  bubbles inserted (see Optional Feature)

Behaviour:
- Reset (rstn=0 at edge): every registered output = 0, out_valid=0, counters=0. Reset takes priority over flush and handshakes.
- Decode is combinational from in_inst. Capture into the register happens on the edge after acceptance, so latency is 1 cycle.
- hazard = in_valid & out_valid & out_ctrl[MEM_READ_BIT] & (out_rd != 0) & (out_rd == in_inst[19:15] | out_rd == in_inst[24:20]).
- rs1/rs2 comparison is always conservative, regardless of instruction format.
- in_ready = rstn & ~flush & ~hazard & (~out_valid | out_ready).
- accept = in_valid & in_ready. On accept, the register loads pc, inst, control word, immediate, and rd/rs1/rs2, and out_valid becomes 1.
- No accept & out_ready & out_valid: the register becomes a bubble. out_valid=0, out_ctrl=0, other fields = 0.
- Hazard with out_ready=1: the load leaves, a bubble is inserted, and in_ready stays 0 that cycle. Next cycle the hazard is clear and the instruction is accepted. Total penalty is exactly 1 cycle.
- Hazard with out_ready=0: hold everything, with no bubble.
- out_valid & ~out_ready: the register holds all fields stable, and in_ready=0.
- flush=1: on the edge, out_valid=0 and all fields = 0, and no accept that cycle, even if in_valid=1. Flush during a hazard stall drops the held load and the stalled instruction is not captured.
- out_ctrl is always gated, so out_valid=0 implies out_ctrl=0.
- Full throughput: with out_ready=1 and no hazards, one instruction per cycle.

Optional Feature:
ID_PERF_CNT_EN defined:
- stall_cnt increments (wrapping at 2^32) every cycle in which in_valid=1 and in_ready=0.
- bubble_cnt increments once per inserted hazard bubble.
- Both counters clear on reset and are unaffected by flush.

ID_PERF_CNT_EN undefined:
- Both ports remain present and are tied to 0.
- No counter registers are synthesised.

Test Plan:
- Reset: hold rstn=0 with in_valid=1 for 3 cycles → out_valid=0, all outputs 0, in_ready=0. Release → the first instruction is captured on the next edge.
- Throughput: present addi x1,x0,5 at pc=0x0, then add x2,x1,x1 at pc=0x4, with out_ready=1 → out_valid=1 on consecutive cycles with out_pc 0x0 then 0x4, out_imm=5 then 0, in_ready constantly 1.
- Load-use: ld x5,8(x2) then add x6,x5,x7 → exactly one out_valid=0 cycle with out_ctrl=0 between them; bubble_cnt=1 and stall_cnt=1 with the macro defined.
- rd=x0: ld x0,0(x1) then add x3,x0,x0 → no bubble, back-to-back issue.
- Backpressure: out_ready=0 for 4 cycles with a valid register → all outputs stable and in_ready=0. Raise out_ready → the next instruction appears on the following cycle.
- Flush: assert flush for 1 cycle during a load-use stall → out_valid=0 on the next cycle and the stalled add is not emitted. The following instruction at the redirect pc=0x100 is captured normally.

Source files
------------

// File: rtl/id_stage_pipe.sv
// Registered, stallable instruction-decode stage with ID/EX register, flush and load-use bubbles.
// Optional performance counters are enabled by defining ID_PERF_CNT_EN.

module controller #(
  parameter int unsigned CTRL_W = 24
) (
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  output logic [CTRL_W-1:0] ctrl
);
  // Layout: [2:0] funct3, [3] funct7[5], [4] alu_src, [5] reg_write, [6] mem_write,
  // [7] branch, [8] jal, [9] jalr, [10] lui, [11] auipc, [12] word op, [18:16] imm_sel,
  // [19] mem_to_reg, [20] mem_read, [21] illegal.
  logic [23:0] c;

  always_comb begin
    c        = '0;
    c[2:0]   = funct3;
    c[3]     = funct7_5;
    unique case (opcode)
      7'h03: begin c[4] = 1'b1; c[5] = 1'b1; c[18:16] = 3'd1; c[19] = 1'b1; c[20] = 1'b1; end
      7'h13: begin c[4] = 1'b1; c[5] = 1'b1; c[18:16] = 3'd1; end
      7'h1b: begin c[4] = 1'b1; c[5] = 1'b1; c[12] = 1'b1; c[18:16] = 3'd1; end
      7'h23: begin c[4] = 1'b1; c[6] = 1'b1; c[18:16] = 3'd2; end
      7'h33: begin c[5] = 1'b1; end
      7'h3b: begin c[5] = 1'b1; c[12] = 1'b1; end
      7'h63: begin c[7] = 1'b1; c[18:16] = 3'd3; end
      7'h6f: begin c[5] = 1'b1; c[8] = 1'b1; c[18:16] = 3'd5; end
      7'h67: begin c[4] = 1'b1; c[5] = 1'b1; c[9] = 1'b1; c[18:16] = 3'd1; end
      7'h37: begin c[4] = 1'b1; c[5] = 1'b1; c[10] = 1'b1; c[18:16] = 3'd4; end
      7'h17: begin c[4] = 1'b1; c[5] = 1'b1; c[11] = 1'b1; c[18:16] = 3'd4; end
      default: c[21] = 1'b1;
    endcase
    ctrl = CTRL_W'(c);
  end
endmodule

module imm_gen #(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:7]     inst_hi,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm
);
  logic [31:0] i32;

  // Bit positions below are instruction bit positions (inst_hi[k] = inst[k]).
  always_comb begin
    i32 = '0;
    unique case (sel)
      3'd1: i32 = {{20{inst_hi[31]}}, inst_hi[31:20]};
      3'd2: i32 = {{20{inst_hi[31]}}, inst_hi[31:25], inst_hi[11:7]};
      3'd3: i32 = {{20{inst_hi[31]}}, inst_hi[7], inst_hi[30:25], inst_hi[11:8], 1'b0};
      3'd4: i32 = {inst_hi[31:12], 12'b0};
      3'd5: i32 = {{12{inst_hi[31]}}, inst_hi[19:12], inst_hi[20], inst_hi[30:21], 1'b0};
      default: i32 = '0;
    endcase
    imm = XLEN'(signed'(i32));
  end
endmodule

module id_stage_pipe #(
  parameter int unsigned XLEN         = 64,
  parameter int unsigned CTRL_W       = 24,
  parameter int unsigned MEM_READ_BIT = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [31:0]       out_inst,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
);
  logic [CTRL_W-1:0] dec_ctrl;
  logic [XLEN-1:0]   dec_imm;

  controller #(.CTRL_W(CTRL_W)) u_controller (
    .opcode  (in_inst[6:0]),
    .funct3  (in_inst[14:12]),
    .funct7_5(in_inst[30]),
    .ctrl    (dec_ctrl)
  );

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_hi(in_inst[31:7]),
    .sel    (dec_ctrl[18:16]),
    .imm    (dec_imm)
  );

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic              hazard, accept;

  // Conservative: rs1/rs2 compared even for formats that do not read them.
  assign hazard = in_valid & valid_q & ctrl_q[MEM_READ_BIT] & (inst_q[11:7] != 5'd0) &
                  ((inst_q[11:7] == in_inst[19:15]) | (inst_q[11:7] == in_inst[24:20]));
  assign in_ready = rstn & ~flush & ~hazard & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ctrl_d  = ctrl_q;
    imm_d   = imm_q;
    if (accept) begin
      valid_d = 1'b1;
      pc_d    = in_pc;
      inst_d  = in_inst;
      ctrl_d  = dec_ctrl;
      imm_d   = dec_imm;
    end else if (flush || (out_ready && valid_q)) begin
      valid_d = 1'b0;
      pc_d    = '0;
      inst_d  = '0;
      ctrl_d  = '0;
      imm_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= '0;
      ctrl_q  <= '0;
      imm_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ctrl_q  <= ctrl_d;
      imm_q   <= imm_d;
    end
  end

  assign out_valid = valid_q;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;
  assign out_ctrl  = valid_q ? ctrl_q : '0;
  assign out_imm   = imm_q;
  assign out_rd    = inst_q[11:7];
  assign out_rs1   = inst_q[19:15];
  assign out_rs2   = inst_q[24:20];

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_q, bubble_q;
  logic        bubble_ins;

  assign bubble_ins = hazard & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (in_valid && !in_ready) stall_q <= stall_q + 32'd1;
      if (bubble_ins) bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus randomized traffic against a reference model.
// Counter expectations follow ID_PERF_CNT_EN when it is defined for the build.

module tb_id_stage_pipe;
  logic        clk = 1'b0;
  logic        rstn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [31:0] in_inst, out_inst, stall_cnt, bubble_cnt;
  logic [23:0] out_ctrl;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: content of the ID/EX register and counters
  bit          m_valid;
  logic [63:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_stall, m_bubble;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(64), .CTRL_W(24), .MEM_READ_BIT(20)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_inst  (out_inst),
    .out_ctrl  (out_ctrl),
    .out_imm   (out_imm),
    .out_rd    (out_rd),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected control word per opcode class, then funct3 and inst[30] ride along.
  function automatic logic [23:0] ctrl_of(input logic [31:0] i);
    logic [23:0] c;
    case (i[6:0])
      7'h03:   c = 24'h190030;
      7'h13:   c = 24'h010030;
      7'h1b:   c = 24'h011030;
      7'h23:   c = 24'h020050;
      7'h33:   c = 24'h000020;
      7'h3b:   c = 24'h001020;
      7'h63:   c = 24'h030080;
      7'h6f:   c = 24'h050120;
      7'h67:   c = 24'h010230;
      7'h37:   c = 24'h040430;
      7'h17:   c = 24'h040830;
      default: c = 24'h200000;
    endcase
    return c | {20'b0, i[30], i[14:12]};
  endfunction

  function automatic logic [63:0] imm_of(input logic [31:0] i);
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    case (i[6:0])
      7'h03, 7'h13, 7'h1b, 7'h67: begin s12 = i[31:20]; return {{52{s12[11]}}, s12}; end
      7'h23: begin s12 = {i[31:25], i[11:7]}; return {{52{s12[11]}}, s12}; end
      7'h63: begin b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; return {{51{b13[12]}}, b13}; end
      7'h37, 7'h17: return {{32{i[31]}}, i[31:12], 12'b0};
      7'h6f: begin j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; return {{43{j21[20]}}, j21}; end
      default: return 64'd0;
    endcase
  endfunction

  // One clock: compare everything at the negedge, advance the model at the posedge.
  task automatic tick();
    bit haz, rdy;
    logic [4:0] rd;
    bit n_valid;
    logic [63:0] n_pc;
    logic [31:0] n_inst, n_stall, n_bubble;
    @(negedge clk);
    rd  = m_inst[11:7];
    haz = in_valid && m_valid && (m_inst[6:0] == 7'h03) && (rd != 5'd0) &&
          (rd == in_inst[19:15] || rd == in_inst[24:20]);
    rdy = rstn && !flush && !haz && (!m_valid || out_ready);
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_pc", out_pc, m_pc);
    check("out_inst", 64'(out_inst), 64'(m_inst));
    check("out_ctrl", 64'(out_ctrl), m_valid ? 64'(ctrl_of(m_inst)) : 64'd0);
    check("out_imm", out_imm, m_valid ? imm_of(m_inst) : 64'd0);
    check("out_rd", 64'(out_rd), 64'(m_inst[11:7]));
    check("out_rs1", 64'(out_rs1), 64'(m_inst[19:15]));
    check("out_rs2", 64'(out_rs2), 64'(m_inst[24:20]));
`ifdef ID_PERF_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
    check("bubble_cnt", 64'(bubble_cnt), 64'(m_bubble));
`else
    check("stall_cnt", 64'(stall_cnt), 64'd0);
    check("bubble_cnt", 64'(bubble_cnt), 64'd0);
`endif
    n_valid = m_valid; n_pc = m_pc; n_inst = m_inst;
    n_stall = m_stall; n_bubble = m_bubble;
    if (!rstn) begin
      n_valid = 0; n_pc = '0; n_inst = '0; n_stall = '0; n_bubble = '0;
    end else begin
      if (in_valid && !rdy) n_stall = m_stall + 1;
      if (haz && out_ready && !flush) n_bubble = m_bubble + 1;
      if (in_valid && rdy) begin
        n_valid = 1; n_pc = in_pc; n_inst = in_inst;
      end else if (flush || (out_ready && m_valid)) begin
        n_valid = 0; n_pc = '0; n_inst = '0;
      end
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_pc = n_pc; m_inst = n_inst;
    m_stall = n_stall; m_bubble = n_bubble;
  endtask

  task automatic offer(input logic [63:0] pc, input logic [31:0] inst, input logic ordy);
    in_valid = 1'b1; in_pc = pc; in_inst = inst; out_ready = ordy;
  endtask

  localparam logic [31:0] AddiX1 = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] AddX2  = 32'h00108133; // add  x2,x1,x1
  localparam logic [31:0] LdX5   = 32'h00813283; // ld   x5,8(x2)
  localparam logic [31:0] AddX6  = 32'h00728333; // add  x6,x5,x7
  localparam logic [31:0] LdX0   = 32'h0000b003; // ld   x0,0(x1)
  localparam logic [31:0] AddX3  = 32'h000001b3; // add  x3,x0,x0

  logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h1b, 7'h23, 7'h33, 7'h3b, 7'h63, 7'h6f, 7'h67,
                           7'h37, 7'h17};

  initial begin
    rstn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    offer(64'h0, AddiX1, 1'b1);
    @(posedge clk);
    #1;
    m_valid = 0; m_pc = '0; m_inst = '0; m_stall = '0; m_bubble = '0;

    // Reset held with a pending instruction
    repeat (3) tick();
    check("reset_valid", 64'(out_valid), 64'd0);

    // Throughput
    rstn = 1'b1;
    offer(64'h0, AddiX1, 1'b1);
    tick();
    check("tp0_pc", out_pc, 64'h0);
    check("tp0_imm", out_imm, 64'd5);
    offer(64'h4, AddX2, 1'b1);
    tick();
    check("tp1_valid", 64'(out_valid), 64'd1);
    check("tp1_pc", out_pc, 64'h4);
    check("tp1_imm", out_imm, 64'd0);

    // Load-use: one bubble
    offer(64'h8, LdX5, 1'b1);
    tick();
    offer(64'hc, AddX6, 1'b1);
    tick();
    check("lu_bubble_valid", 64'(out_valid), 64'd0);
    check("lu_bubble_ctrl", 64'(out_ctrl), 64'd0);
    tick();
    check("lu_add_pc", out_pc, 64'hc);
`ifdef ID_PERF_CNT_EN
    check("lu_bubble_cnt", 64'(bubble_cnt), 64'd1);
    check("lu_stall_cnt", 64'(stall_cnt), 64'd1);
`endif

    // Load to x0 never stalls
    offer(64'h10, LdX0, 1'b1);
    tick();
    offer(64'h14, AddX3, 1'b1);
    tick();
    check("x0_pc", out_pc, 64'h14);

    // Backpressure
    offer(64'h18, AddiX1, 1'b1);
    tick();
    offer(64'h1c, AddX2, 1'b0);
    repeat (4) tick();
    check("bp_hold_pc", out_pc, 64'h18);
    out_ready = 1'b1;
    tick();
    check("bp_next_pc", out_pc, 64'h1c);

    // Flush during a held load-use stall
    offer(64'h20, LdX5, 1'b1);
    tick();
    offer(64'h24, AddX6, 1'b0);
    tick();
    flush = 1'b1;
    tick();
    check("fl_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    offer(64'h100, AddiX1, 1'b1);
    tick();
    check("fl_redirect_pc", out_pc, 64'h100);
    check("fl_redirect_inst", 64'(out_inst), 64'(AddiX1));

    // Randomized traffic with a small register pool to provoke hazards
    for (int n = 0; n < 2000; n++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 9) != 0) begin
        w[6:0]   = ops[$urandom_range(0, 10)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
      end
      in_inst   = w;
      in_pc     = {$urandom, $urandom};
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      rstn      = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
